// File: rtl/in_debounce.sv
// Per-channel input debouncer with registered glitch-free output, change strobe and busy flag.
// Define IN_DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer ahead of each channel's debounce FSM.
module in_debounce #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] i_raw,
    output logic [0:WIDTH-1] o_stable,
    output logic             o_changed,
    output logic             o_busy
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_COUNT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:WIDTH-1]            x;
    logic [0:WIDTH-1]            st;
    logic [0:WIDTH-1]            st_nxt;
    logic [0:WIDTH-1]            s_nxt;
    logic [0:WIDTH-1]            upd;
    logic [0:WIDTH-1][CNT_W-1:0] cnt;
    logic [0:WIDTH-1][CNT_W-1:0] cnt_nxt;
    logic                        busy_nxt;

`ifdef IN_DEBOUNCE_SYNC_EN
    logic [0:WIDTH-1] sync_p0;
    logic [0:WIDTH-1] sync_p1;

    // Stage p0/p1: metastability filter on the raw asynchronous levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= i_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign x = sync_p1;
`else
    assign x = i_raw;
`endif

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        s_nxt    = o_stable;
        upd      = '0;
        busy_nxt = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            case (st[k])
                ST_IDLE: begin
                    if (x[k] != o_stable[k]) begin
                        st_nxt[k]  = ST_COUNT;
                        cnt_nxt[k] = CNT_ONE;
                    end
                end
                ST_COUNT: begin
                    if (x[k] == o_stable[k]) begin
                        // Bounced back before the level was trusted: discard the run
                        st_nxt[k]  = ST_IDLE;
                        cnt_nxt[k] = '0;
                    end else if (cnt[k] == CNT_LAST) begin
                        st_nxt[k]  = ST_IDLE;
                        cnt_nxt[k] = '0;
                        s_nxt[k]   = x[k];
                        upd[k]     = 1'b1;
                    end else begin
                        cnt_nxt[k] = cnt[k] + CNT_ONE;
                    end
                end
                default: begin
                    st_nxt[k]  = ST_IDLE;
                    cnt_nxt[k] = '0;
                end
            endcase
            if (cnt_nxt[k] != '0) begin
                busy_nxt = 1'b1;
            end
        end
    end

    // Stage p2: debounce state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= '0;
            cnt       <= '0;
            o_stable  <= '0;
            o_changed <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            o_stable  <= s_nxt;
            o_changed <= |upd;
            o_busy    <= busy_nxt;
        end
    end

endmodule
